// File: rtl/mem_stage.sv
// MIPS memory stage: word loads/stores over a req/ack data bus with a bounded
// wait, StallM back-pressure to execute, and the MEM/WB pipeline register.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  WriteRegM,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  output logic        StallM,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [31:0] DMemWData,
  input  logic [31:0] DMemRData,
  input  logic        DMemAck,
  output logic [31:0] ALUOutW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  WriteRegW,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic        ExcW,
  output logic [1:0]  ExcCodeW,
  output logic [31:0] ResultW
);

  localparam int unsigned    DW       = 32;
  localparam int unsigned    RW       = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0]     EXC_NONE = 2'b00;
  localparam logic [1:0]     EXC_ALGN = 2'b01;
  localparam logic [1:0]     EXC_TOUT = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [DW-1:0]    rbuf, rbuf_nxt;
  logic             err, err_nxt;
  logic             stall_c;

  logic             req_nxt, we_nxt;
  logic [DW-1:0]    addr_nxt, wdata_nxt;
  logic [DW-1:0]    alu_w_nxt, rd_w_nxt;
  logic [RW-1:0]    wreg_w_nxt;
  logic             regw_w_nxt, m2r_w_nxt, exc_w_nxt;
  logic [1:0]       code_w_nxt;

  logic mem_op, misaligned;
  assign mem_op     = MemtoRegM | MemWriteM;
  assign misaligned = mem_op & (ALUOutM[1:0] != 2'b00);

  // Next-state, bus request and MEM/WB register update.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    rbuf_nxt   = rbuf;
    err_nxt    = err;
    stall_c    = 1'b0;
    req_nxt    = DMemReq;
    we_nxt     = DMemWe;
    addr_nxt   = DMemAddr;
    wdata_nxt  = DMemWData;
    alu_w_nxt  = ALUOutW;
    rd_w_nxt   = ReadDataW;
    wreg_w_nxt = WriteRegW;
    regw_w_nxt = RegWriteW;
    m2r_w_nxt  = MemtoRegW;
    exc_w_nxt  = ExcW;
    code_w_nxt = ExcCodeW;

    case (state)
      IDLE: begin
        if (!mem_op) begin
          alu_w_nxt  = ALUOutM;
          wreg_w_nxt = WriteRegM;
          regw_w_nxt = RegWriteM;
          m2r_w_nxt  = 1'b0;
          exc_w_nxt  = 1'b0;
          code_w_nxt = EXC_NONE;
        end else if (misaligned) begin
          alu_w_nxt  = ALUOutM;
          wreg_w_nxt = WriteRegM;
          regw_w_nxt = 1'b0;
          m2r_w_nxt  = 1'b0;
          exc_w_nxt  = 1'b1;
          code_w_nxt = EXC_ALGN;
        end else begin
          stall_c   = 1'b1;
          addr_nxt  = {ALUOutM[31:2], 2'b00};
          wdata_nxt = WriteDataM;
          // A load+store combination is issued as a load.
          we_nxt    = MemWriteM & ~MemtoRegM;
          req_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        stall_c = 1'b1;
        if (DMemAck) begin
          req_nxt   = 1'b0;
          rbuf_nxt  = DMemRData;
          err_nxt   = 1'b0;
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          req_nxt   = 1'b0;
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        alu_w_nxt  = ALUOutM;
        wreg_w_nxt = WriteRegM;
        rd_w_nxt   = rbuf;
        m2r_w_nxt  = MemtoRegM;
        regw_w_nxt = RegWriteM & ~err;
        exc_w_nxt  = err;
        code_w_nxt = err ? EXC_TOUT : EXC_NONE;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rbuf      <= '0;
      err       <= 1'b0;
      DMemReq   <= 1'b0;
      DMemWe    <= 1'b0;
      DMemAddr  <= '0;
      DMemWData <= '0;
      ALUOutW   <= '0;
      ReadDataW <= '0;
      WriteRegW <= '0;
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      ExcW      <= 1'b0;
      ExcCodeW  <= EXC_NONE;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rbuf      <= rbuf_nxt;
      err       <= err_nxt;
      DMemReq   <= req_nxt;
      DMemWe    <= we_nxt;
      DMemAddr  <= addr_nxt;
      DMemWData <= wdata_nxt;
      ALUOutW   <= alu_w_nxt;
      ReadDataW <= rd_w_nxt;
      WriteRegW <= wreg_w_nxt;
      RegWriteW <= regw_w_nxt;
      MemtoRegW <= m2r_w_nxt;
      ExcW      <= exc_w_nxt;
      ExcCodeW  <= code_w_nxt;
    end
  end

  // Stall is forced low while reset is held so execute is released at once.
  assign StallM  = rst_n & stall_c;
  assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage: driver pushes expected W-stage
// results and bus requests; a monitor and a memory responder check them.
module tb_mem_stage;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ALUOutM, WriteDataM, DMemAddr, DMemWData, DMemRData;
  logic [31:0] ALUOutW, ReadDataW, ResultW;
  logic [4:0]  WriteRegM, WriteRegW;
  logic        RegWriteM, MemtoRegM, MemWriteM, StallM, DMemReq, DMemWe, DMemAck;
  logic        RegWriteW, MemtoRegW, ExcW;
  logic [1:0]  ExcCodeW;

  mem_stage #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .MemWriteM(MemWriteM), .StallM(StallM), .DMemReq(DMemReq), .DMemWe(DMemWe),
    .DMemAddr(DMemAddr), .DMemWData(DMemWData), .DMemRData(DMemRData),
    .DMemAck(DMemAck), .ALUOutW(ALUOutW), .ReadDataW(ReadDataW),
    .WriteRegW(WriteRegW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .ExcW(ExcW), .ExcCodeW(ExcCodeW), .ResultW(ResultW)
  );

  typedef struct {
    logic [31:0] alu, rd;
    logic [4:0]  wreg;
    logic        regw, m2r, exc, chk_rd, chk_res;
    logic [1:0]  code;
  } wexp_t;

  typedef struct {
    logic [31:0] addr, wdata, rdata;
    logic        we;
    int          delay;
  } req_t;

  wexp_t wq[$];
  req_t  rq[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle that was not stalled produces one MEM/WB result.
  logic  pending = 1'b0;
  wexp_t e;
  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 1'b0;
    end else begin
      if (pending) begin
        if (wq.size() == 0) begin
          chk("w_unexpected", 32'(1), 32'(0));
        end else begin
          e = wq.pop_front();
          chk("ALUOutW", ALUOutW, e.alu);
          chk("WriteRegW", 32'(WriteRegW), 32'(e.wreg));
          chk("RegWriteW", 32'(RegWriteW), 32'(e.regw));
          chk("MemtoRegW", 32'(MemtoRegW), 32'(e.m2r));
          chk("ExcW", 32'(ExcW), 32'(e.exc));
          chk("ExcCodeW", 32'(ExcCodeW), 32'(e.code));
          if (e.chk_rd)  chk("ReadDataW", ReadDataW, e.rd);
          if (e.chk_res) chk("ResultW", ResultW, e.m2r ? e.rd : e.alu);
        end
      end
      pending = !StallM;
    end
  end

  // Memory responder: checks request fields, acks after the planned delay.
  task automatic serve();
    req_t r;
    if (rq.size() == 0) begin
      chk("req_unexpected", 32'(1), 32'(0));
      return;
    end
    r = rq.pop_front();
    chk("DMemAddr", DMemAddr, r.addr);
    chk("DMemWe", 32'(DMemWe), 32'(r.we));
    chk("DMemWData", DMemWData, r.wdata);
    for (int k = 0; k <= int'(TO); k++) begin
      if (!rst_n) return;
      if (k == int'(TO)) begin
        chk("req_drop_timeout", 32'(DMemReq), 32'(0));
        if (r.delay == int'(TO)) begin
          DMemAck = 1'b1;
          DMemRData = $urandom;
          @(negedge clk);
          DMemAck = 1'b0;
        end
        return;
      end
      chk("req_held", 32'(DMemReq), 32'(1));
      if (k == r.delay) begin
        DMemAck = 1'b1;
        DMemRData = r.rdata;
        @(negedge clk);
        DMemAck = 1'b0;
        DMemRData = $urandom;
        if (rst_n) chk("req_drop_ack", 32'(DMemReq), 32'(0));
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    DMemAck = 1'b0;
    DMemRData = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n && DMemReq) serve();
    end
  end

  // Present one instruction, build its expected outcome from the stage rules.
  task automatic issue(input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] wr,
                       input logic regw, input logic m2r, input logic mw,
                       input int delay, input logic [31:0] rdata);
    wexp_t x;
    req_t  r;
    logic  memop, mis, tout;
    int    n, exp_n;
    ALUOutM = addr; WriteDataM = wd; WriteRegM = wr;
    RegWriteM = regw; MemtoRegM = m2r; MemWriteM = mw;
    memop = m2r | mw;
    mis   = memop && (addr % 4 != 0);
    tout  = delay >= int'(TO);
    x.alu = addr; x.wreg = wr; x.rd = rdata; x.chk_rd = 1'b0; x.chk_res = 1'b1;
    exp_n = 0;
    if (!memop) begin
      x.regw = regw; x.m2r = 1'b0; x.exc = 1'b0; x.code = 2'd0;
    end else if (mis) begin
      x.regw = 1'b0; x.m2r = 1'b0; x.exc = 1'b1; x.code = 2'd1;
    end else begin
      x.m2r = m2r;
      x.regw = regw && !tout;
      x.exc = tout;
      x.code = tout ? 2'd2 : 2'd0;
      x.chk_rd = m2r && !tout;
      x.chk_res = !(m2r && tout);
      exp_n = 1 + ((delay + 1 < int'(TO)) ? delay + 1 : int'(TO));
      r.addr = addr; r.wdata = wd; r.rdata = rdata; r.we = mw && !m2r; r.delay = delay;
      rq.push_back(r);
    end
    wq.push_back(x);
    n = 0;
    forever begin
      @(negedge clk);
      if (!StallM) break;
      n++;
      if (n > 40) begin
        chk("stall_bound", 32'(n), 32'(exp_n));
        break;
      end
    end
    chk("stall_cycles", 32'(n), 32'(exp_n));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    int          kind, n;
    ALUOutM = '0; WriteDataM = '0; WriteRegM = '0;
    RegWriteM = 1'b0; MemtoRegM = 1'b0; MemWriteM = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_DMemReq", 32'(DMemReq), 32'(0));
    chk("rst_StallM", 32'(StallM), 32'(0));
    chk("rst_ALUOutW", ALUOutW, 32'h0);
    chk("rst_RegWriteW", 32'(RegWriteW), 32'(0));
    chk("rst_ExcW", 32'(ExcW), 32'(0));
    rst_n = 1'b1;

    issue(32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    issue(32'h0000_0100, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 2, 32'hDEAD_BEEF);
    issue(32'h0000_0204, 32'hA5A5_A5A5, 5'd0, 1'b0, 1'b0, 1'b1, 0, 32'h0);
    issue(32'h0000_0102, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 0, 32'h0);
    issue(32'h0000_0300, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, int'(TO), 32'h1111_2222);
    issue(32'h0000_0304, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, int'(TO) - 1, 32'h3333_4444);
    issue(32'h0000_0308, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1, 32'h5555_6666);

    for (int i = 0; i < 200; i++) begin
      kind = int'($urandom_range(0, 4));
      a = $urandom;
      if (kind == 4) a[1:0] = 2'($urandom_range(1, 3));
      else if (kind != 0) a[1:0] = 2'b00;
      case (kind)
        0: issue(a, $urandom, 5'($urandom), 1'($urandom), 1'b0, 1'b0, 0, 32'h0);
        1: issue(a, $urandom, 5'($urandom), 1'($urandom), 1'b1, 1'b0,
                 int'($urandom_range(0, TO + 1)), $urandom);
        2: issue(a, $urandom, 5'($urandom), 1'($urandom), 1'b0, 1'b1,
                 int'($urandom_range(0, TO + 1)), $urandom);
        3: issue(a, $urandom, 5'($urandom), 1'($urandom), 1'b1, 1'b1,
                 int'($urandom_range(0, TO + 1)), $urandom);
        default: issue(a, $urandom, 5'($urandom), 1'b1, 1'($urandom), 1'b1, 0, 32'h0);
      endcase
    end

    // Make sure W holds something nonzero before the reset check.
    issue(32'hCAFE_0010, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    // Reset pulsed during WAIT: request abandoned, everything cleared at once.
    ALUOutM = 32'h0000_0400; WriteDataM = 32'h0; WriteRegM = 5'd9;
    RegWriteM = 1'b1; MemtoRegM = 1'b1; MemWriteM = 1'b0;
    rq.push_back('{addr: 32'h400, wdata: 32'h0, rdata: 32'h0, we: 1'b0, delay: 99});
    n = 0;
    while (!DMemReq && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rstw_req_seen", 32'(DMemReq), 32'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstw_DMemReq", 32'(DMemReq), 32'(0));
    chk("rstw_StallM", 32'(StallM), 32'(0));
    chk("rstw_ALUOutW", ALUOutW, 32'h0);
    chk("rstw_WriteRegW", 32'(WriteRegW), 32'(0));
    chk("rstw_RegWriteW", 32'(RegWriteW), 32'(0));
    chk("rstw_ExcW", 32'(ExcW), 32'(0));
    chk("rstw_DMemAddr", DMemAddr, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(32'h0000_5678, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 0, 32'h0);

    @(negedge clk);
    #1;
    chk("wq_drained", 32'(wq.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
